// File: rtl/alu_pkg.sv
// Shared widths and ALU opcode constants for the ALU issue path.
package alu_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int INST_WIDTH_DEF = 4;

  localparam logic [3:0] ADD_S = 4'd0;
  localparam logic [3:0] SUB_S = 4'd1;
  localparam logic [3:0] MUL_S = 4'd2;
  localparam logic [3:0] MAX_S = 4'd3;
  localparam logic [3:0] MIN_S = 4'd4;
  localparam logic [3:0] ADD_U = 4'd5;
  localparam logic [3:0] SUB_U = 4'd6;
  localparam logic [3:0] MUL_U = 4'd7;
  localparam logic [3:0] MAX_U = 4'd8;
  localparam logic [3:0] MIN_U = 4'd9;
  localparam logic [3:0] AND   = 4'd10;
  localparam logic [3:0] OR    = 4'd11;
  localparam logic [3:0] XOR   = 4'd12;
  localparam logic [3:0] NOT   = 4'd13;
  localparam logic [3:0] REV   = 4'd14;
endpackage

// File: rtl/alu_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
module alu_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

  assign o_data  = mem[rd_ptr];
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign o_empty = (o_count == '0);
endmodule

// File: rtl/alu_issuer.sv
// Queues ALU commands, issues them one per cycle to a 1-cycle ALU and
// buffers the results in order, reserving response space before issuing.
module alu_issuer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int INST_WIDTH = INST_WIDTH_DEF,
  parameter int CMD_DEPTH  = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [DATA_WIDTH-1:0] i_cmd_a,
  input  logic [DATA_WIDTH-1:0] i_cmd_b,
  input  logic [INST_WIDTH-1:0] i_cmd_inst,
  output logic                  o_alu_valid,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [INST_WIDTH-1:0] o_alu_inst,
  input  logic [DATA_WIDTH-1:0] i_alu_data,
  input  logic                  i_alu_overflow,
  input  logic                  i_alu_valid,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_overflow,
  output logic [7:0]            o_ovf_count,
  output logic                  o_err,
  output logic                  o_busy
);
  localparam int CMD_W = 2*DATA_WIDTH + INST_WIDTH;
  localparam int RSP_W = DATA_WIDTH + 1;
  localparam int CCW   = $clog2(CMD_DEPTH);
  localparam int RCW   = $clog2(RSP_DEPTH);

  logic             cmd_full, cmd_empty;
  logic [CCW:0]     cmd_count;
  logic [CMD_W-1:0] cmd_head;
  logic             rsp_full, rsp_empty;
  logic [RCW:0]     rsp_count;
  logic [RSP_W-1:0] rsp_head;
  logic [1:0]       pending;
  logic [RCW+1:0]   rsp_occ;
  logic             issue, rsp_push, rsp_pop, cmd_push;

  // Ready comes from the registered count only; a full FIFO stays closed even on an issue cycle.
  assign o_cmd_ready = !cmd_full;
  assign cmd_push    = i_cmd_valid && o_cmd_ready;

  alu_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (cmd_push),
    .i_data  ({i_cmd_a, i_cmd_b, i_cmd_inst}),
    .i_pop   (issue),
    .o_data  (cmd_head),
    .o_full  (cmd_full),
    .o_empty (cmd_empty),
    .o_count (cmd_count)
  );

  // Every in-flight op owns a response slot, so results can never be dropped.
  assign rsp_occ  = {1'b0, rsp_count} + {{RCW{1'b0}}, pending};
  assign issue    = !cmd_empty && !rsp_full && (rsp_occ < (RCW+2)'(RSP_DEPTH));
  assign rsp_push = i_alu_valid && (pending != 2'd0);
  assign rsp_pop  = !rsp_empty && i_rsp_ready;

  alu_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (rsp_push),
    .i_data  ({i_alu_data, i_alu_overflow}),
    .i_pop   (rsp_pop),
    .o_data  (rsp_head),
    .o_full  (rsp_full),
    .o_empty (rsp_empty),
    .o_count (rsp_count)
  );

  assign o_rsp_valid    = !rsp_empty;
  assign o_rsp_data     = rsp_empty ? '0 : rsp_head[RSP_W-1:1];
  assign o_rsp_overflow = !rsp_empty && rsp_head[0];
  assign o_busy         = (cmd_count != '0) || (pending != 2'd0) || (rsp_count != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_alu_valid <= 1'b0;
      o_alu_a     <= '0;
      o_alu_b     <= '0;
      o_alu_inst  <= '0;
      pending     <= 2'd0;
      o_ovf_count <= 8'd0;
      o_err       <= 1'b0;
    end else begin
      o_alu_valid <= issue;
      if (issue) {o_alu_a, o_alu_b, o_alu_inst} <= cmd_head;
      case ({issue, rsp_push})
        2'b10:   pending <= pending + 2'd1;
        2'b01:   pending <= pending - 2'd1;
        default: pending <= pending;
      endcase
      if (i_alu_valid && (pending == 2'd0)) o_err <= 1'b1;
      if (rsp_push && i_alu_overflow && (o_ovf_count != 8'hFF))
        o_ovf_count <= o_ovf_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_alu_issuer.sv
// Self-checking bench: acts as the 1-cycle ALU and scoreboards issuer behaviour.
module tb_alu_issuer;
  typedef struct packed {logic [31:0] a; logic [31:0] b; logic [3:0] inst;} cmd_t;
  typedef struct packed {logic [31:0] data; logic ovf;} rsp_t;
  typedef struct {logic [31:0] a; logic [31:0] b; logic [3:0] inst; logic [31:0] data; logic ovf;} vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_cmd_valid = 1'b0, o_cmd_ready;
  logic [31:0] i_cmd_a = '0, i_cmd_b = '0;
  logic [3:0]  i_cmd_inst = '0;
  logic        o_alu_valid;
  logic [31:0] o_alu_a, o_alu_b;
  logic [3:0]  o_alu_inst;
  logic [31:0] i_alu_data = '0;
  logic        i_alu_overflow = 1'b0, i_alu_valid = 1'b0;
  logic        o_rsp_valid, i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_data;
  logic        o_rsp_overflow;
  logic [7:0]  o_ovf_count;
  logic        o_err, o_busy;

  always #5 i_clk = ~i_clk;

  alu_issuer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b), .i_cmd_inst(i_cmd_inst),
    .o_alu_valid(o_alu_valid), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_inst(o_alu_inst),
    .i_alu_data(i_alu_data), .i_alu_overflow(i_alu_overflow), .i_alu_valid(i_alu_valid),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_overflow(o_rsp_overflow),
    .o_ovf_count(o_ovf_count), .o_err(o_err), .o_busy(o_busy)
  );

  cmd_t cq[$];
  rsp_t fq[$], rq[$];
  int   total = 0, bad = 0, ovf_exp = 0, n_issue = 0, n_pop = 0;
  bit   err_exp = 0, force_alu = 0, last_acc = 0, alu_v_d = 0, alu_o_d = 0;
  logic [31:0] alu_d_d = '0;

  function automatic rsp_t alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    rsp_t r;
    logic [32:0] s;
    r.ovf = 1'b0;
    case (op)
      4'd0: begin r.data = a + b; r.ovf = (a[31] == b[31]) && (r.data[31] != a[31]); end
      4'd1: begin r.data = a - b; r.ovf = (a[31] != b[31]) && (r.data[31] != a[31]); end
      4'd5: begin s = {1'b0, a} + {1'b0, b}; r.data = s[31:0]; r.ovf = s[32]; end
      4'd6: begin r.data = a - b; r.ovf = (a < b); end
      4'd10: r.data = a & b;
      4'd11: r.data = a | b;
      4'd12: r.data = a ^ b;
      default: r.data = ~a;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    bit   acc, pop, exp_issue;
    cmd_t nc, c;
    rsp_t r;
    acc = i_cmd_valid && o_cmd_ready;
    pop = o_rsp_valid && i_rsp_ready;
    exp_issue = (cq.size() > 0) && ((rq.size() + fq.size()) < 4);
    nc = '{a: i_cmd_a, b: i_cmd_b, inst: i_cmd_inst};
    if (pop) begin
      n_pop++;
      if (rq.size() == 0) chk("rsp_extra", o_rsp_valid, 0);
      else begin
        chk("rsp_data", o_rsp_data, rq[0].data);
        chk("rsp_ovf", o_rsp_overflow, rq[0].ovf);
        void'(rq.pop_front());
      end
    end
    @(posedge i_clk); #1;
    last_acc = acc;
    if (acc) cq.push_back(nc);
    if (i_alu_valid) begin
      if (fq.size() > 0) begin
        r = fq.pop_front();
        rq.push_back(r);
        if (r.ovf && ovf_exp < 255) ovf_exp++;
      end else err_exp = 1;
    end
    chk("alu_valid", o_alu_valid, exp_issue);
    if (o_alu_valid) begin
      n_issue++;
      if (cq.size() == 0) chk("issue_empty", o_alu_valid, 0);
      else begin
        c = cq.pop_front();
        chk("alu_a", o_alu_a, c.a);
        chk("alu_b", o_alu_b, c.b);
        chk("alu_inst", o_alu_inst, c.inst);
        fq.push_back(alu_f(c.a, c.b, c.inst));
      end
    end
    // ALU: result appears the cycle after the issue strobe
    i_alu_valid    = force_alu ? 1'b1 : alu_v_d;
    i_alu_data     = force_alu ? $urandom : alu_d_d;
    i_alu_overflow = force_alu ? 1'b1 : alu_o_d;
    r = alu_f(o_alu_a, o_alu_b, o_alu_inst);
    alu_v_d = o_alu_valid; alu_d_d = r.data; alu_o_d = r.ovf;
    chk("busy", o_busy, (cq.size() + fq.size() + rq.size()) != 0);
    chk("rsp_valid", o_rsp_valid, rq.size() != 0);
    chk("cmd_ready", o_cmd_ready, cq.size() < 4);
    chk("ovf_count", o_ovf_count, ovf_exp);
    chk("err", o_err, err_exp);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_cmd_valid = 0; i_rsp_ready = 0; i_alu_valid = 0; i_alu_overflow = 0;
    force_alu = 0; alu_v_d = 0; alu_o_d = 0;
    cq.delete(); fq.delete(); rq.delete();
    ovf_exp = 0; err_exp = 0; n_issue = 0; n_pop = 0;
    #2;
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_alu_valid", o_alu_valid, 0);
    chk("rst_alu_a", o_alu_a, 0);
    chk("rst_alu_b", o_alu_b, 0);
    chk("rst_alu_inst", o_alu_inst, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_data", o_rsp_data, 0);
    chk("rst_rsp_ovf", o_rsp_overflow, 0);
    chk("rst_ovf_count", o_ovf_count, 0);
    chk("rst_err", o_err, 0);
    chk("rst_busy", o_busy, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] inst);
    bit done = 0;
    i_cmd_valid = 1; i_cmd_a = a; i_cmd_b = b; i_cmd_inst = inst;
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      done = last_acc;
    end
    i_cmd_valid = 0;
    if (!done) chk("accept_timeout", o_cmd_ready, 1);
  endtask

  task automatic drain();
    i_cmd_valid = 0; i_rsp_ready = 1;
    for (int k = 0; k < 60 && o_busy; k++) step();
    step();
    chk("drain_idle", o_busy, 0);
    i_rsp_ready = 0;
  endtask

  vec_t vecs[9];
  bit   got;

  initial begin
    vecs[0] = '{32'd3, 32'd5, 4'd0, 32'd8, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'd1, 4'd5, 32'd0, 1'b1};
    vecs[2] = '{32'h7FFFFFFF, 32'd1, 4'd0, 32'h80000000, 1'b1};
    vecs[3] = '{32'h80000000, 32'd1, 4'd1, 32'h7FFFFFFF, 1'b1};
    vecs[4] = '{32'd5, 32'd3, 4'd6, 32'd2, 1'b0};
    vecs[5] = '{32'd3, 32'd5, 4'd6, 32'hFFFFFFFE, 1'b1};
    vecs[6] = '{32'hF0F0, 32'hFF00, 4'd10, 32'hF000, 1'b0};
    vecs[7] = '{32'hF0F0, 32'hFF00, 4'd12, 32'h0FF0, 1'b0};
    vecs[8] = '{32'd9, 32'd4, 4'd15, 32'hFFFFFFF6, 1'b0};
    #1;
    do_reset();

    // Single commands: table of operands and expected ALU responses
    for (int i = 0; i < 9; i++) begin
      push_cmd(vecs[i].a, vecs[i].b, vecs[i].inst);
      for (int k = 0; k < 10 && !o_rsp_valid; k++) step();
      chk("vec_rsp_valid", o_rsp_valid, 1);
      chk("vec_data", o_rsp_data, vecs[i].data);
      chk("vec_ovf", o_rsp_overflow, vecs[i].ovf);
      drain();
    end

    // Four overflowing adds held with downstream stalled, then drained
    do_reset();
    for (int i = 0; i < 4; i++) push_cmd(32'hFFFFFFFF, 32'd1, 4'd5);
    repeat (8) step();
    chk("burst_issued", n_issue, 4);
    chk("burst_ovf", o_ovf_count, 4);
    push_cmd(32'd1, 32'd1, 4'd0);
    repeat (5) step();
    chk("burst_stall", n_issue, 4);
    drain();
    chk("burst_pops", n_pop, 5);

    // Command FIFO fill while issue is blocked by a full response FIFO
    do_reset();
    for (int i = 0; i < 4; i++) push_cmd(i, 32'd7, 4'd0);
    repeat (6) step();
    for (int i = 0; i < 4; i++) push_cmd(32'd100 + i, 32'd1, 4'd5);
    chk("full_ready_low", o_cmd_ready, 0);
    i_cmd_valid = 1; i_cmd_a = 32'd200; i_cmd_b = 32'd2; i_cmd_inst = 4'd0;
    got = 0;
    for (int k = 0; k < 5; k++) begin step(); got |= last_acc; end
    chk("fifth_blocked", got, 0);
    i_rsp_ready = 1; step(); i_rsp_ready = 0;
    for (int k = 0; k < 6 && !got; k++) begin step(); got = last_acc; end
    i_cmd_valid = 0;
    chk("fifth_accepted", got, 1);
    drain();

    // Spurious ALU result
    do_reset();
    force_alu = 1; step(); force_alu = 0;
    repeat (5) step();
    chk("err_sticky", o_err, 1);
    chk("err_no_rsp", o_rsp_valid, 0);
    do_reset();
    step();
    chk("err_cleared", o_err, 0);

    // Reset with two held and two in flight
    do_reset();
    for (int i = 0; i < 4; i++) begin
      i_cmd_valid = 1; i_cmd_a = 32'd10 + i; i_cmd_b = 32'd1; i_cmd_inst = 4'd0;
      step();
    end
    i_cmd_valid = 0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      got = (rq.size() == 2) && (fq.size() == 2);
      if (!got) step();
    end
    chk("midrst_reached", got, 1);
    chk("midrst_busy", o_busy, 1);
    do_reset();
    i_rsp_ready = 1;
    repeat (6) step();
    chk("midrst_no_rsp", o_rsp_valid, 0);
    chk("midrst_pops", n_pop, 0);
    i_rsp_ready = 0;

    // Randomised traffic against the scoreboard
    do_reset();
    for (int k = 0; k < 600; k++) begin
      i_cmd_valid = 1'($urandom_range(0, 1));
      i_cmd_a = $urandom; i_cmd_b = $urandom;
      i_cmd_inst = 4'($urandom_range(0, 15));
      i_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Overflow counter saturation
    do_reset();
    i_rsp_ready = 1;
    for (int i = 0; i < 300; i++) push_cmd(32'hFFFFFFFF, 32'd1, 4'd5);
    drain();
    chk("ovf_sat", o_ovf_count, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter INST_WIDTH, default 4, opcode width.
REQ-003 Parameter CMD_DEPTH, default 4, command FIFO entries (power of 2).
REQ-004 Parameter RSP_DEPTH, default 4, response FIFO entries (power of 2, >=3).
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 i_clk  in  1  clock, all state rising-edge.
REQ-007 i_rst_n  in  1  async active-low reset.
REQ-008 i_cmd_valid  in  1  upstream command valid.
REQ-009 o_cmd_ready  out  1  command FIFO not full.
REQ-010 i_cmd_a / i_cmd_b  in  DATA_WIDTH  operands.
REQ-011 i_cmd_inst  in  INST_WIDTH  ALU opcode, 0..14; other values pass through unchanged.
REQ-012 o_alu_valid  out  1  one-cycle issue strobe to ALU i_valid.
REQ-013 o_alu_a / o_alu_b / o_alu_inst  out  DATA_WIDTH/DATA_WIDTH/INST_WIDTH  issued operands and opcode.
REQ-014 i_alu_data / i_alu_overflow / i_alu_valid  in  DATA_WIDTH/1/1  ALU result port.
REQ-015 o_rsp_valid  out  1  response FIFO not empty.
REQ-016 i_rsp_ready  in  1  downstream accepts response.
REQ-017 o_rsp_data / o_rsp_overflow  out  DATA_WIDTH/1  head-of-FIFO result.
REQ-018 o_ovf_count  out  8  saturating count of overflowed results.
REQ-019 o_err  out  1  sticky protocol error.
REQ-020 o_busy  out  1  any command queued, in flight, or response held.

Function
REQ-021 Command accepted on a cycle with i_cmd_valid && o_cmd_ready, written to command FIFO in order.
REQ-022 o_alu_a/b/inst/valid driven from registers; issue = pop one command and set o_alu_valid for exactly one cycle.
REQ-023 ALU result latency 1 register: i_alu_valid for an issue appears the cycle after o_alu_valid is high.
REQ-024 pending counter (0..2) +1 on issue, -1 on i_alu_valid while pending>0; both same cycle leaves it unchanged.
REQ-025 Issue allowed only when command FIFO non-empty and rsp_count + pending < RSP_DEPTH; back-to-back issue every cycle otherwise.
REQ-026 On i_alu_valid, {i_alu_data, i_alu_overflow} pushed to response FIFO; never dropped given REQ-025.
REQ-027 i_alu_valid with pending==0: result discarded, o_err set until reset.
REQ-028 Response popped on o_rsp_valid && i_rsp_ready; push and pop same cycle keeps count; pop on full permitted with simultaneous push.
REQ-029 Commands full + push same cycle as issue-pop: o_cmd_ready reflects registered count only (no combinational bypass).
REQ-030 o_ovf_count +1 per pushed result with overflow=1, holds at 255.
REQ-031 When not issuing, o_alu_valid=0 and o_alu_a/b/inst hold last issued values.
REQ-032 Results delivered strictly in command order; no reordering, no data change.
REQ-033 o_busy = cmd_count!=0 || pending!=0 || rsp_count!=0.

Reset
REQ-034 Reset mid-operation discards all queued, in-flight and held data; no response emitted for it.
REQ-035 Reset values: o_cmd_ready=1, o_alu_valid=0, o_alu_a/b/inst=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_overflow=0, o_ovf_count=0, o_err=0, o_busy=0, pending=0, all FIFO pointers 0.

Structure
REQ-036 Shared package alu_pkg holds DATA_WIDTH/INST_WIDTH defaults and opcode constants (ADD_S=0, SUB_S=1, MUL_S=2, MAX_S=3, MIN_S=4, ADD_U=5, SUB_U=6, MUL_U=7, MAX_U=8, MIN_U=9, AND=10, OR=11, XOR=12, NOT=13, REV=14).
REQ-037 One sub-module alu_fifo (parameterised width/depth, sync, full/empty/count) instantiated twice: command (2*DATA_WIDTH+INST_WIDTH) and response (DATA_WIDTH+1).

Verification
REQ-038 Single cmd a=3,b=5,inst=0, rsp_ready=1, paired with ALU -> one response data=8, overflow=0, o_busy low afterwards.
REQ-039 Burst of 4 cmds inst=5 with a=0xFFFFFFFF,b=1 each, rsp_ready=0 -> issue stalls at 4 held, o_ovf_count=4, then rsp_ready=1 drains 4 responses data=0 in order.
REQ-040 5 cmds pushed back-to-back with ALU issue stalled -> o_cmd_ready low after 4th, 5th accepted only after first issue.
REQ-041 i_alu_valid forced high with nothing issued -> o_err=1, no response, o_err held until reset.
REQ-042 Reset asserted with 2 in flight and 2 responses held -> all outputs at reset values, no stale response after release.
REQ-043 300 overflowing results -> o_ovf_count saturates at 255.
